// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and lane masks.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ST_RD = 3'd2,
    S_ST_WR = 3'd3,
    S_RESP  = 3'd4
  } lsu_state_e;

  localparam logic [31:0] LANE_MASK_B = 32'h0000_00FF;
  localparam logic [31:0] LANE_MASK_H = 32'h0000_FFFF;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: extract+extend for loads, mask+merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] rd,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] mask;

  assign sh = {addr_lo, 3'b000};

  always_comb begin
    lane      = rd >> sh;
    load_data = rd;
    mask      = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{lane[7] & ~uns}}, lane[7:0]};
        mask      = LANE_MASK_B << sh;
      end
      SZ_HALF: begin
        load_data = {{16{lane[15] & ~uns}}, lane[15:0]};
        mask      = LANE_MASK_H << sh;
      end
      default: ;
    endcase
    // Store data is masked too, so junk above the right-justified lane never leaks in.
    merged = (rd & ~mask) | ((wdata << sh) & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses at byte addresses mapped onto a word-only memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic [2:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE. The response is a single-cycle resp_valid pulse
  // with no back-pressure.

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged;

  lsu_lane_align u_align (
    .addr_lo   (addr_q[1:0]),
    .size      (size_q),
    .uns       (uns_q),
    .rd        (mem_rd),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  assign req_err = (req_size == SZ_ILL)
                 | ((req_size == SZ_HALF) & req_addr[0])
                 | ((req_size == SZ_WORD) & (|req_addr[1:1+0] | req_addr[0]))
                 | ({2'b00, req_addr[31:2]} >= MEM_WORDS);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          err_d   = req_err;
          merge_d = req_wdata;
          rdata_d = '0;
          // Errors ride through the LOAD slot so they answer with the same latency as a load.
          if (req_err || !req_we)      state_d = S_LOAD;
          else if (req_size == SZ_WORD) state_d = S_ST_WR;
          else                          state_d = S_ST_RD;
        end
      end
      S_LOAD: begin
        rdata_d = (err_q || we_q) ? '0 : load_data;
        state_d = S_RESP;
      end
      S_ST_RD: begin
        merge_d = merged;
        state_d = S_ST_WR;
      end
      S_ST_WR: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = (state_q == S_RESP) & err_q;
  assign resp_rdata = (state_q == S_RESP) ? rdata_q : '0;
  assign mem_we     = (state_q == S_ST_WR);
  assign mem_a      = {addr_q[31:2], 2'b00};
  assign mem_wd     = (state_q == S_ST_WR) ? merge_q : '0;
  assign dbg_state  = state_q;

endmodule
